mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single synchronous data/instruction memory port between two requesters:
  - port 0: the CPU (fetch, LDR, STR);
  - port 1: a DMA/program loader.
- Arbitrates between them, sequences each access through a small FSM and returns read data with a one-cycle done pulse.
- Sits between the requesters and the RAM; it owns mem_cmd, mem_addr and mem_wdata.

Parameters:
- AW, 9, address width.
- DW, 16, data width.
- READ_LAT, 1, RAM read latency in cycles (legal 1..3).
- CPU_PRIORITY, 0, 1 = CPU always wins simultaneous requests; 0 = round-robin.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low (asserted when 0)
- cpu_cmd  in  2  00 none, 01 MREAD, 10 MWRITE, 11 illegal (treated as none)
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data, registered
- cpu_done  out  1  one-cycle completion pulse
- dma_cmd, dma_addr, dma_wdata, dma_rdata, dma_done  same as cpu_* for port 1
- mem_cmd  out  2  RAM command, registered
- mem_addr  out  AW  RAM address, registered
- mem_wdata  out  DW  RAM write data, registered
- mem_rdata  in  DW  RAM read data, valid READ_LAT cycles after address presented
- busy  out  1  1 whenever state != IDLE
- owner  out  1  port of the current/last grant (0 CPU, 1 DMA)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_owner=1, owner=0.
  - mem_cmd=00, mem_addr=0, mem_wdata=0.
  - cpu_rdata=dma_rdata=0, both done=0, busy=0.
  - Takes effect immediately. An in-flight transaction is aborted with no done pulse.
- States: IDLE, ACCESS, CAPTURE, DONE.
- IDLE:
  - Sample both cmds; a port requests when its cmd is 01 or 10.
  - No request: stay in IDLE, mem_cmd=00.
  - One request: grant it.
  - Both request: CPU_PRIORITY=1 grants CPU; otherwise grant the port != last_owner.
  - At the edge: latch owner, command, address and wdata into mem_* registers; last_owner<=winner; go to ACCESS.
- ACCESS (request seen in cycle T; ACCESS begins in T+1):
  - Write: mem_cmd=10 for exactly one cycle (T+1); the RAM writes at the end of T+1; next state DONE.
  - Read: mem_cmd=01 and mem_addr are held for READ_LAT cycles (T+1..T+READ_LAT) using a 2-bit counter; next state CAPTURE.
- CAPTURE (read only, cycle T+1+READ_LAT):
  - mem_cmd=00.
  - mem_rdata is registered into the owner's rdata at the end of the cycle.
  - Next state DONE.
- DONE:
  - The owner's done=1 for exactly this cycle; mem_cmd=00.
  - Next state IDLE.
  - Write done arrives in T+2; read done arrives in T+2+READ_LAT.
- Handshake:
  - A requester holds cmd/addr/wdata stable until its done pulse.
  - Changes to the owner's inputs during a grant are ignored, because latched values are used.
  - A non-owner may change or drop its request freely; it is only sampled in IDLE.
  - A cmd still asserted in the cycle after done (IDLE) is a new request. Back-to-back requests are therefore legal, with a minimum 1-cycle IDLE gap between grants.
- Read data and pulses:
  - Each rdata holds its last captured value until that port's next read completes.
  - Writes do not change rdata.
  - cpu_done and dma_done are never both 1.
- Fairness:
  - With CPU_PRIORITY=0 and both ports continuously requesting, grants strictly alternate.
  - Each port waits at most one foreign transaction.
  - With CPU_PRIORITY=1, DMA can starve; this is intended, as the CPU fetch path is critical.
- Arithmetic: mem_addr is passed through unmodified; there is no wrap or offset logic.
- Illegal cmd 11: ignored in IDLE. No done is generated and no memory access occurs.

Test Plan:
- Reset/idle: assert reset=0 mid-read (during ACCESS), release → mem_cmd=00, busy=0, no done; first CPU request afterwards is granted normally.
- Single CPU read: READ_LAT=1, cpu_cmd=01, addr=9'h005, RAM[5]=16'hBEEF at T → mem_cmd=01 in T+1, cpu_done=1 in T+3, cpu_rdata=16'hBEEF, dma_rdata unchanged.
- Single DMA write: dma_cmd=10, addr=9'h1FF, wdata=16'h1234 at T → mem_cmd=10 for T+1 only, dma_done in T+2, RAM[1FF]=1234, cpu_rdata unchanged.
- Simultaneous contention, CPU_PRIORITY=0: both ports hold reads to 9'h010 and 9'h020 for 4 transactions → grant order CPU, DMA, CPU, DMA, each with correct rdata, never two dones in one cycle.
- Priority mode: CPU_PRIORITY=1, both ports request continuously → every grant goes to CPU; DMA is granted only in the cycle after CPU drops its cmd.
- Latency and illegal cmd: READ_LAT=3 → read done exactly 5 cycles after request, mem_cmd held for 3 cycles; cpu_cmd=11 alone for 10 cycles → busy stays 0, mem_cmd stays 00.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (CPU/DMA) arbiter and sequencer for one synchronous RAM port
//
// Purpose: grants the single RAM port to the CPU (port 0) or DMA (port 1),
// sequences the access (IDLE -> ACCESS -> [CAPTURE] -> DONE), returns read
// data per port and pulses that port's done for one cycle.
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   cpu_cmd/addr/wdata         CPU request (cmd 01 read, 10 write, 00/11 none)
//   cpu_rdata, cpu_done        CPU registered read data, one-cycle completion
//   dma_*                      same as cpu_* for the DMA/loader port
//   mem_cmd/addr/wdata         registered RAM command, address, write data
//   mem_rdata                  RAM read data, valid READ_LAT cycles after address
//   busy                       high whenever a transaction is in progress
//   owner                      port of the current/last grant (0 CPU, 1 DMA)
module mem_port_arbiter #(
  parameter int AW           = 9,
  parameter int DW           = 16,
  parameter int READ_LAT     = 1,
  parameter int CPU_PRIORITY = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cpu_cmd,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  input  logic [1:0]    dma_cmd,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_done,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  // Last count value of the read hold; mem_cmd stays READ for READ_LAT cycles.
  localparam logic [1:0] LAT_LAST  = 2'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  state_t     state;
  logic       last_owner;
  logic [1:0] lat_cnt;
  logic       cpu_req;
  logic       dma_req;
  logic       grant_dma;

  // Command 11 is not a request.
  assign cpu_req = (cpu_cmd == CMD_READ) || (cpu_cmd == CMD_WRITE);
  assign dma_req = (dma_cmd == CMD_READ) || (dma_cmd == CMD_WRITE);

  // On contention, round-robin hands the grant to the port that did not win last.
  always_comb begin
    grant_dma = dma_req;
    if (cpu_req && dma_req) begin
      grant_dma = (CPU_PRIORITY != 0) ? 1'b0 : ~last_owner;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      lat_cnt    <= 2'd0;
      mem_cmd    <= CMD_NONE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      cpu_done   <= 1'b0;
      dma_done   <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      dma_done <= 1'b0;
      case (state)
        IDLE: begin
          mem_cmd <= CMD_NONE;
          if (cpu_req || dma_req) begin
            // Latch the winner's request; its inputs are not looked at again.
            owner      <= grant_dma;
            last_owner <= grant_dma;
            mem_cmd    <= grant_dma ? dma_cmd   : cpu_cmd;
            mem_addr   <= grant_dma ? dma_addr  : cpu_addr;
            mem_wdata  <= grant_dma ? dma_wdata : cpu_wdata;
            lat_cnt    <= 2'd0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_cmd == CMD_WRITE) begin
            // The RAM writes at the end of this single ACCESS cycle.
            mem_cmd <= CMD_NONE;
            state   <= DONE;
            if (owner) dma_done <= 1'b1;
            else       cpu_done <= 1'b1;
          end else if (lat_cnt == LAT_LAST) begin
            mem_cmd <= CMD_NONE;
            state   <= CAPTURE;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        CAPTURE: begin
          if (owner) begin
            dma_rdata <= mem_rdata;
            dma_done  <= 1'b1;
          end else begin
            cpu_rdata <= mem_rdata;
            cpu_done  <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  // Instance 0: READ_LAT=1 round-robin; 1: READ_LAT=1 CPU priority; 2: READ_LAT=3 round-robin.
  localparam int N = 3;
  int lat [N] = '{1, 1, 3};
  bit pri [N] = '{1'b0, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  cpu_cmd [N];
  logic [8:0]  cpu_addr [N];
  logic [15:0] cpu_wdata [N];
  logic [15:0] cpu_rdata [N];
  logic        cpu_done [N];
  logic [1:0]  dma_cmd [N];
  logic [8:0]  dma_addr [N];
  logic [15:0] dma_wdata [N];
  logic [15:0] dma_rdata [N];
  logic        dma_done [N];
  logic [1:0]  mem_cmd [N];
  logic [8:0]  mem_addr [N];
  logic [15:0] mem_wdata [N];
  logic [15:0] mem_rdata [N];
  logic        busy [N];
  logic        owner [N];

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(9), .DW(16), .READ_LAT(1), .CPU_PRIORITY(0)) dut_rr (
    .clk(clk), .reset(reset),
    .cpu_cmd(cpu_cmd[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_rdata(cpu_rdata[0]), .cpu_done(cpu_done[0]),
    .dma_cmd(dma_cmd[0]), .dma_addr(dma_addr[0]), .dma_wdata(dma_wdata[0]),
    .dma_rdata(dma_rdata[0]), .dma_done(dma_done[0]),
    .mem_cmd(mem_cmd[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .owner(owner[0]));

  mem_port_arbiter #(.AW(9), .DW(16), .READ_LAT(1), .CPU_PRIORITY(1)) dut_pri (
    .clk(clk), .reset(reset),
    .cpu_cmd(cpu_cmd[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_rdata(cpu_rdata[1]), .cpu_done(cpu_done[1]),
    .dma_cmd(dma_cmd[1]), .dma_addr(dma_addr[1]), .dma_wdata(dma_wdata[1]),
    .dma_rdata(dma_rdata[1]), .dma_done(dma_done[1]),
    .mem_cmd(mem_cmd[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .owner(owner[1]));

  mem_port_arbiter #(.AW(9), .DW(16), .READ_LAT(3), .CPU_PRIORITY(0)) dut_l3 (
    .clk(clk), .reset(reset),
    .cpu_cmd(cpu_cmd[2]), .cpu_addr(cpu_addr[2]), .cpu_wdata(cpu_wdata[2]),
    .cpu_rdata(cpu_rdata[2]), .cpu_done(cpu_done[2]),
    .dma_cmd(dma_cmd[2]), .dma_addr(dma_addr[2]), .dma_wdata(dma_wdata[2]),
    .dma_rdata(dma_rdata[2]), .dma_done(dma_done[2]),
    .mem_cmd(mem_cmd[2]), .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]),
    .mem_rdata(mem_rdata[2]), .busy(busy[2]), .owner(owner[2]));

  function automatic logic [15:0] init_val(input int k, input int a);
    if (a == 5) return 16'hBEEF;
    return 16'((a * 291) ^ (k << 12) ^ 23130);
  endfunction

  // RAM environment: synchronous write, read pipeline of depth READ_LAT.
  logic [15:0] ram [N][512];
  logic [15:0] pipe [N][3];
  bit          ram_ready;

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (!ram_ready) begin
        for (int a = 0; a < 512; a++) ram[k][a] <= init_val(k, a);
      end else if (mem_cmd[k] == 2'b10) begin
        ram[k][mem_addr[k]] <= mem_wdata[k];
      end
      pipe[k][0] <= ram[k][mem_addr[k]];
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
    ram_ready <= 1'b1;
  end

  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][0];
  assign mem_rdata[2] = pipe[2][2];

  // Transaction-level reference state.
  logic [15:0] smem [N][512];
  int          m_last [N];
  logic [15:0] m_crd [N];
  logic [15:0] m_drd [N];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_last[k] = 1;
      m_crd[k]  = 16'h0;
      m_drd[k]  = 16'h0;
    end
  endtask

  // Presents both ports' requests in one IDLE cycle (cycle 0), holds each
  // until its done, and checks every cycle against the predicted schedule.
  task automatic round(input int k,
                       input logic [1:0] cc, input logic [8:0] ca, input logic [15:0] cw,
                       input logic [1:0] dc, input logic [8:0] da, input logic [15:0] dw);
    bit          req [2];
    int          order [$];
    int          exp_done [2];
    logic [15:0] exp_rd [2];
    logic [1:0]  cmd_p [2];
    logic [8:0]  addr_p [2];
    logic [15:0] wd_p [2];
    int          t, w, p;
    cmd_p  = '{cc, dc};
    addr_p = '{ca, da};
    wd_p   = '{cw, dw};
    req[0] = (cc == 2'b01) || (cc == 2'b10);
    req[1] = (dc == 2'b01) || (dc == 2'b10);
    if (req[0] && req[1]) begin
      w = pri[k] ? 0 : (m_last[k] == 0 ? 1 : 0);
      order.push_back(w);
      order.push_back(1 - w);
    end else if (req[0]) begin
      order.push_back(0);
    end else if (req[1]) begin
      order.push_back(1);
    end
    exp_done = '{-1, -1};
    exp_rd   = '{m_crd[k], m_drd[k]};
    t = 0;
    foreach (order[i]) begin
      p = order[i];
      if (cmd_p[p] == 2'b10) begin
        smem[k][addr_p[p]] = wd_p[p];
        exp_done[p] = t + 2;
      end else begin
        exp_rd[p]   = smem[k][addr_p[p]];
        exp_done[p] = t + 2 + lat[k];
      end
      m_last[k] = p;
      t = exp_done[p] + 1;
    end
    cpu_cmd[k] = cc; cpu_addr[k] = ca; cpu_wdata[k] = cw;
    dma_cmd[k] = dc; dma_addr[k] = da; dma_wdata[k] = dw;
    for (int cyc = 1; cyc <= t + 1; cyc++) begin
      @(negedge clk);
      if (cyc == 1 && order.size() > 0) begin
        chk("grant_owner", 32'(owner[k]), order[0]);
        chk("grant_mem_cmd", 32'(mem_cmd[k]), 32'(cmd_p[order[0]]));
        chk("grant_mem_addr", 32'(mem_addr[k]), 32'(addr_p[order[0]]));
        if (cmd_p[order[0]] == 2'b10)
          chk("grant_mem_wdata", 32'(mem_wdata[k]), 32'(wd_p[order[0]]));
      end
      chk("cpu_done", 32'(cpu_done[k]), 32'(cyc == exp_done[0]));
      chk("dma_done", 32'(dma_done[k]), 32'(cyc == exp_done[1]));
      if (cyc == exp_done[0]) begin
        chk("cpu_rdata_at_done", 32'(cpu_rdata[k]), 32'(exp_rd[0]));
        cpu_cmd[k] = 2'b00;
      end
      if (cyc == exp_done[1]) begin
        chk("dma_rdata_at_done", 32'(dma_rdata[k]), 32'(exp_rd[1]));
        dma_cmd[k] = 2'b00;
      end
    end
    chk("idle_busy", 32'(busy[k]), 0);
    chk("idle_mem_cmd", 32'(mem_cmd[k]), 0);
    chk("end_cpu_rdata", 32'(cpu_rdata[k]), 32'(exp_rd[0]));
    chk("end_dma_rdata", 32'(dma_rdata[k]), 32'(exp_rd[1]));
    cpu_cmd[k] = 2'b00;
    dma_cmd[k] = 2'b00;
    m_crd[k] = exp_rd[0];
    m_drd[k] = exp_rd[1];
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      cpu_cmd[k] = 2'b00; cpu_addr[k] = '0; cpu_wdata[k] = '0;
      dma_cmd[k] = 2'b00; dma_addr[k] = '0; dma_wdata[k] = '0;
      for (int a = 0; a < 512; a++) smem[k][a] = init_val(k, a);
    end
    model_reset();
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_mem_cmd", 32'(mem_cmd[0]), 0);
    chk("rst_mem_addr", 32'(mem_addr[0]), 0);
    chk("rst_mem_wdata", 32'(mem_wdata[0]), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata[0]), 0);
    chk("rst_dma_rdata", 32'(dma_rdata[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_owner", 32'(owner[0]), 0);
    reset = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of a read.
    cpu_cmd[0] = 2'b01; cpu_addr[0] = 9'h007;
    @(posedge clk);
    #2;
    chk("pre_abort_busy", 32'(busy[0]), 1);
    reset = 1'b0;
    #1;
    chk("abort_mem_cmd", 32'(mem_cmd[0]), 0);
    chk("abort_busy", 32'(busy[0]), 0);
    cpu_cmd[0] = 2'b00;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_cpu_done", 32'(cpu_done[0]), 0);
      chk("abort_dma_done", 32'(dma_done[0]), 0);
    end
    reset = 1'b1;
    @(negedge clk);

    // Single CPU read, single DMA write, then sustained contention.
    round(0, 2'b01, 9'h005, 16'h0000, 2'b00, 9'h000, 16'h0000);
    chk("cpu_read_beef", 32'(cpu_rdata[0]), 32'h0000BEEF);
    round(0, 2'b00, 9'h000, 16'h0000, 2'b10, 9'h1FF, 16'h1234);
    chk("ram_1ff", 32'(ram[0][9'h1FF]), 32'h00001234);
    round(0, 2'b01, 9'h010, 16'h0000, 2'b01, 9'h020, 16'h0000);
    round(0, 2'b01, 9'h010, 16'h0000, 2'b01, 9'h020, 16'h0000);
    round(0, 2'b01, 9'h1FF, 16'h0000, 2'b11, 9'h000, 16'h0000);

    // CPU priority: CPU re-requests back to back, DMA only after CPU lets go.
    cpu_cmd[1] = 2'b01; cpu_addr[1] = 9'h010;
    dma_cmd[1] = 2'b01; dma_addr[1] = 9'h020;
    for (int cyc = 1; cyc <= 28; cyc++) begin
      @(negedge clk);
      chk("pri_cpu_done", 32'(cpu_done[1]), 32'((cyc % 4 == 3) && (cyc <= 23)));
      chk("pri_dma_done", 32'(dma_done[1]), 32'(cyc == 27));
      if (cyc == 23) begin
        chk("pri_cpu_rdata", 32'(cpu_rdata[1]), 32'(smem[1][9'h010]));
        cpu_cmd[1] = 2'b00;
      end
      if (cyc == 27) begin
        chk("pri_dma_rdata", 32'(dma_rdata[1]), 32'(smem[1][9'h020]));
        dma_cmd[1] = 2'b00;
      end
    end
    m_last[1] = 1;
    m_crd[1]  = smem[1][9'h010];
    m_drd[1]  = smem[1][9'h020];

    // READ_LAT=3: command held three cycles, done five cycles after request.
    cpu_cmd[2] = 2'b01; cpu_addr[2] = 9'h033;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      chk("l3_mem_cmd", 32'(mem_cmd[2]), (cyc <= 3) ? 1 : 0);
      chk("l3_busy", 32'(busy[2]), (cyc <= 5) ? 1 : 0);
      chk("l3_cpu_done", 32'(cpu_done[2]), 32'(cyc == 5));
      if (cyc == 5) begin
        chk("l3_cpu_rdata", 32'(cpu_rdata[2]), 32'(smem[2][9'h033]));
        cpu_cmd[2] = 2'b00;
      end
    end
    m_last[2] = 0;
    m_crd[2]  = smem[2][9'h033];

    // Illegal command 11 is never a request.
    cpu_cmd[2] = 2'b11;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      chk("ill_busy", 32'(busy[2]), 0);
      chk("ill_mem_cmd", 32'(mem_cmd[2]), 0);
      chk("ill_cpu_done", 32'(cpu_done[2]), 0);
    end
    cpu_cmd[2] = 2'b00;

    // Randomized rounds over all instances on a small address window.
    for (int r = 0; r < 60; r++) begin
      round($urandom_range(N - 1, 0),
            2'($urandom_range(3, 0)), 9'($urandom_range(15, 0)), 16'($urandom),
            2'($urandom_range(3, 0)), 9'($urandom_range(15, 0)), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
